modaddsub_serial: RTL and testbench

Parametrised, limb-serial modular adder/subtractor/negator: computes (a + b) mod m, (a − b) mod m or (−b) mod m for operands of WIDTH bits, processing LIMB bits per clock. Both the raw sum/difference and the modulus-corrected value are computed limb by limb in a single pass, and the correct one is selected at the end. It replaces the fixed-width two-adder modular adder in the field-arithmetic datapath, so the same block serves every curve size. Operands are captured at start, so the caller can change its inputs while the block is busy.

---
 rtl/modaddsub_serial_if.sv | 25 ++
 rtl/modaddsub_serial.sv | 185 ++++++++++++++++++
 tb/tb_modaddsub_serial.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/modaddsub_serial_if.sv
// Handshake and operand bus for the limb-serial modular adder/subtractor.
// The master drives the request and operands; the slave returns status and the result.
interface modaddsub_serial_if #(
  parameter int WIDTH = 381
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, in_a, in_b, in_m,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, op, in_a, in_b, in_m,
    output ready, busy, done, result
  );
endinterface

// File: rtl/modaddsub_serial.sv
// Limb-serial modular adder / subtractor / negator.
// Computes (a+b) mod m, (a-b) mod m or (-b) mod m, LIMB bits per clock.
// Raw value s and corrected value t are built side by side in one pass;
// the final carries pick the right one. One extension bit above WIDTH keeps
// a+b <= 2m-2 from ever wrapping the internal width.
module modaddsub_serial #(
  parameter int WIDTH = 381,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             rst,
  modaddsub_serial_if.slave bus
);

  // ceil((WIDTH+1)/LIMB): at least one spare bit above the operand width
  localparam int NLIMB = (WIDTH + LIMB) / LIMB;
  localparam int EW    = NLIMB * LIMB;
  localparam int CW    = $clog2(NLIMB + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEL  = 2'd2
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // operand shift registers (consumed LSB limb first)
  logic [EW-1:0]    a_r;
  logic [EW-1:0]    b_r;
  logic [EW-1:0]    m_r;
  // raw and corrected results (filled from the MSB end)
  logic [EW-1:0]    s_r;
  logic [EW-1:0]    t_r;
  logic             is_add_r;
  logic             c1_r;
  logic             c2_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] result_r;
  logic             done_r;
  logic             ready_r;
  logic             busy_r;

  logic [LIMB-1:0]  b_limb_s;
  logic [LIMB-1:0]  m_limb_s;
  logic [LIMB:0]    s_sum_s;
  logic [LIMB:0]    t_sum_s;
  logic             last_limb_s;
  logic             take_t_s;
  logic             is_add_op_s;

  // One limb of addition with carry in; the carry out is the top bit.
  function automatic logic [LIMB:0] limb_add(
    input logic [LIMB-1:0] x,
    input logic [LIMB-1:0] y,
    input logic            cin
  );
    limb_add = {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, cin};
  endfunction

  // Zero-extend a WIDTH-bit operand to the internal limb width.
  function automatic logic [EW-1:0] widen(input logic [WIDTH-1:0] x);
    widen = {{(EW-WIDTH){1'b0}}, x};
  endfunction

  // Per-limb datapath: two chained limb additions and the final selector.
  always_comb begin
    b_limb_s    = is_add_r ? b_r[LIMB-1:0] : ~b_r[LIMB-1:0];
    s_sum_s     = limb_add(a_r[LIMB-1:0], b_limb_s, c1_r);
    m_limb_s    = is_add_r ? ~m_r[LIMB-1:0] : m_r[LIMB-1:0];
    t_sum_s     = limb_add(s_sum_s[LIMB-1:0], m_limb_s, c2_r);
    last_limb_s = (cnt_r == CW'(NLIMB - 1));
    // add: c2 set means s >= m, use s-m; sub/neg: c1 clear means a < b, use s+m
    take_t_s    = is_add_r ? c2_r : ~c1_r;
    // op 00 and op 11 both add
    is_add_op_s = ~(bus.op[1] ^ bus.op[0]);
  end

  // Next-state logic for the IDLE / RUN / SEL sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (last_limb_s) begin
          next_state_s = SEL;
        end else begin
          next_state_s = RUN;
        end
      end
      SEL: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand capture and limb-serial shift/accumulate datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      m_r      <= '0;
      s_r      <= '0;
      t_r      <= '0;
      is_add_r <= 1'b0;
      c1_r     <= 1'b0;
      c2_r     <= 1'b0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            // neg is computed as 0 - b
            a_r      <= (bus.op == 2'b10) ? '0 : widen(bus.in_a);
            b_r      <= widen(bus.in_b);
            m_r      <= widen(bus.in_m);
            is_add_r <= is_add_op_s;
            c1_r     <= ~is_add_op_s;
            c2_r     <= is_add_op_s;
            cnt_r    <= '0;
          end
        end
        RUN: begin
          a_r   <= a_r >> LIMB;
          b_r   <= b_r >> LIMB;
          m_r   <= m_r >> LIMB;
          s_r   <= (s_r >> LIMB) | (EW'(s_sum_s[LIMB-1:0]) << (EW - LIMB));
          t_r   <= (t_r >> LIMB) | (EW'(t_sum_s[LIMB-1:0]) << (EW - LIMB));
          c1_r  <= s_sum_s[LIMB];
          c2_r  <= t_sum_s[LIMB];
          cnt_r <= cnt_r + CW'(1);
        end
        SEL: begin
          cnt_r <= '0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // Registered outputs: status follows the next state, result updates only with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= '0;
      done_r   <= 1'b0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      done_r  <= (state_r == SEL);
      ready_r <= (next_state_s == IDLE);
      busy_r  <= (next_state_s != IDLE);
      if (state_r == SEL) begin
        result_r <= take_t_s ? t_r[WIDTH-1:0] : s_r[WIDTH-1:0];
      end
    end
  end

  assign bus.result = result_r;
  assign bus.done   = done_r;
  assign bus.ready  = ready_r;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_modaddsub_serial.sv
// Scoreboard bench: a small instance (WIDTH=13, LIMB=4, m=7919) with directed
// vectors and handshake/reset cases, and a default-size instance on the
// BLS12-381 base-field prime with random operations against a golden model.
module tb_modaddsub_serial;

  localparam int SW   = 13;
  localparam int SL   = 4;
  localparam int SLAT = 5;
  localparam int LW   = 381;
  localparam int LL   = 64;
  localparam int LLAT = 7;
  localparam int NRND = 3000;
  localparam logic [LW-1:0] P =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
  localparam logic [SW-1:0] MS = 13'd7919;

  typedef struct {
    logic [LW-1:0] res;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_small;
  logic rst_large;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  exp_t q_s[$];
  exp_t q_l[$];
  exp_t e_ms;
  exp_t e_ml;

  modaddsub_serial_if #(.WIDTH(SW)) bs();
  modaddsub_serial_if #(.WIDTH(LW)) bl();

  modaddsub_serial #(.WIDTH(SW), .LIMB(SL)) dut_s (.clk(clk), .rst(rst_small), .bus(bs));
  modaddsub_serial #(.WIDTH(LW), .LIMB(LL)) dut_l (.clk(clk), .rst(rst_large), .bus(bl));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [LW-1:0] golden(input logic [1:0] op, input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [LW+1:0] x;
    case (op)
      2'b01: x = (a >= b) ? ({2'b00, a} - {2'b00, b}) : ({2'b00, a} + {2'b00, P} - {2'b00, b});
      2'b10: x = (b == '0) ? '0 : ({2'b00, P} - {2'b00, b});
      default: begin
        x = {2'b00, a} + {2'b00, b};
        if (x >= {2'b00, P}) x = x - {2'b00, P};
      end
    endcase
    return x[LW-1:0];
  endfunction

  function automatic logic [LW-1:0] rand_operand();
    logic [383:0] r;
    logic [LW-1:0] v;
    int sel;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    v = r[LW-1:0];
    if (v >= P) v = v - P;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) v = '0;
    else if (sel == 1) v = P - LW'(1);
    return v;
  endfunction

  // Small-instance monitor: result, latency and busy duration per done.
  always @(negedge clk) begin
    if (rst_small) begin
      busy_cnt = 0;
    end else begin
      if (bs.busy) busy_cnt++;
      if (bs.done) begin
        if (q_s.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL small_unexpected_done actual=done required=no_done result=%0d", bs.result);
        end else begin
          e_ms = q_s.pop_front();
          check("small_result", LW'(bs.result), e_ms.res);
          check("small_latency", LW'(cyc - e_ms.cyc), LW'(SLAT + 1));
          check("small_busy_cycles", LW'(busy_cnt), LW'(SLAT));
        end
        busy_cnt = 0;
      end
    end
  end

  // Large-instance monitor: result and latency per done.
  always @(negedge clk) begin
    if (!rst_large && bl.done) begin
      if (q_l.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL large_unexpected_done actual=done required=no_done");
      end else begin
        e_ml = q_l.pop_front();
        check("large_result", bl.result, e_ml.res);
        check("large_latency", LW'(cyc - e_ml.cyc), LW'(LLAT + 1));
      end
    end
  end

  task automatic issue_s(input logic [1:0] op, input int a, input int b, input int exp, input bit want_done);
    int guard = 0;
    exp_t e;
    while (!bs.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bs.ready) begin
      checks++;
      errors++;
      $display("FAIL small_ready_timeout actual=0 required=1");
    end
    bs.op    = op;
    bs.in_a  = SW'(a);
    bs.in_b  = SW'(b);
    bs.in_m  = MS;
    bs.start = 1'b1;
    if (want_done) begin
      e.res = LW'(exp);
      e.cyc = cyc;
      q_s.push_back(e);
    end
    @(negedge clk);
    bs.start = 1'b0;
    bs.op    = 2'($urandom);
    bs.in_a  = SW'($urandom);
    bs.in_b  = SW'($urandom);
    bs.in_m  = SW'($urandom);
  endtask

  task automatic issue_l(input logic [1:0] op, input logic [LW-1:0] a, input logic [LW-1:0] b);
    int guard = 0;
    exp_t e;
    while (!bl.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bl.ready) begin
      checks++;
      errors++;
      $display("FAIL large_ready_timeout actual=0 required=1");
    end
    bl.op    = op;
    bl.in_a  = a;
    bl.in_b  = b;
    bl.in_m  = P;
    bl.start = 1'b1;
    e.res = golden(op, a, b);
    e.cyc = cyc;
    q_l.push_back(e);
    @(negedge clk);
    bl.start = 1'b0;
    bl.in_a  = rand_operand();
    bl.in_b  = rand_operand();
    bl.op    = 2'($urandom);
  endtask

  // Directed vectors: op, a, b, expected result mod 7919
  int vop[10] = '{0, 1, 1, 1, 0, 0, 0, 3, 2, 2};
  int va [10] = '{5000, 100, 200, 4321, 3000, 7918, 7918, 1, 1234, 1234};
  int vb [10] = '{4000, 200, 100, 4321, 4919, 0, 7918, 2, 0, 1};
  int vex[10] = '{1081, 7819, 100, 0, 0, 7918, 7917, 3, 0, 7918};

  initial begin
    int guard;
    bs.start = 1'b0; bs.op = 2'b00; bs.in_a = '0; bs.in_b = '0; bs.in_m = MS;
    bl.start = 1'b0; bl.op = 2'b00; bl.in_a = '0; bl.in_b = '0; bl.in_m = P;
    rst_small = 1'b1;
    rst_large = 1'b1;
    repeat (2) @(negedge clk);
    rst_small = 1'b0;
    rst_large = 1'b0;
    @(negedge clk);

    check("reset_ready", LW'(bs.ready), LW'(1'b1));
    check("reset_busy", LW'(bs.busy), LW'(1'b0));
    check("reset_done", LW'(bs.done), LW'(1'b0));
    check("reset_result", LW'(bs.result), LW'(0));
    check("reset_large_ready", LW'(bl.ready), LW'(1'b1));
    check("reset_large_result", bl.result, LW'(0));

    // directed vectors issued back-to-back
    for (int i = 0; i < 10; i++) issue_s(2'(vop[i]), va[i], vb[i], vex[i], 1'b1);

    // start pulsed while busy is ignored (1+1 -> 2, exactly one done)
    issue_s(2'b00, 1, 1, 2, 1'b1);
    bs.op = 2'b00; bs.in_a = 13'd5; bs.in_b = 13'd5; bs.in_m = MS; bs.start = 1'b1;
    @(negedge clk);
    bs.start = 1'b0;

    // reset during RUN discards the operation and clears result
    issue_s(2'b00, 10, 20, 30, 1'b0);
    @(negedge clk);
    rst_small = 1'b1;
    @(negedge clk);
    rst_small = 1'b0;
    check("abort_ready", LW'(bs.ready), LW'(1'b1));
    check("abort_busy", LW'(bs.busy), LW'(1'b0));
    check("abort_done", LW'(bs.done), LW'(1'b0));
    check("abort_result", LW'(bs.result), LW'(0));
    repeat (10) @(negedge clk);

    // start and reset together: nothing starts
    bs.op = 2'b00; bs.in_a = 13'd7; bs.in_b = 13'd8; bs.in_m = MS; bs.start = 1'b1;
    rst_small = 1'b1;
    @(negedge clk);
    bs.start = 1'b0;
    rst_small = 1'b0;
    check("startrst_busy", LW'(bs.busy), LW'(1'b0));
    check("startrst_ready", LW'(bs.ready), LW'(1'b1));
    repeat (8) @(negedge clk);
    check("startrst_result", LW'(bs.result), LW'(0));

    // normal operation after reset
    issue_s(2'b00, 5000, 4000, 1081, 1'b1);

    // default-size random operations
    for (int i = 0; i < NRND; i++) issue_l(2'($urandom), rand_operand(), rand_operand());

    guard = 0;
    while ((q_s.size() != 0 || q_l.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (q_s.size() != 0 || q_l.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d/%0d required=0/0", q_s.size(), q_l.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
